// File: rtl/core_common.svh
// rtl/core_common.svh - shared memory-bus field ranges for the core
`ifndef CORE_COMMON_SVH
`define CORE_COMMON_SVH

`define MEM_ADDR_R 31
`define MEM_DATA_R 31
`define MEM_STRB_R 3
`define MEM_PRV_R  1

`endif

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - fetch/LSU arbiter onto one shared memory bus; CORE_MEM_ARB_RR_EN selects round-robin ties
`include "core_common.svh"

module core_mem_arbiter #(
  parameter int FETCH_STARVE_MAX = 8
) (
  input  logic                 g_clk,
  input  logic                 g_reset,

  input  logic                 imem_req,
  input  logic [`MEM_ADDR_R:0] imem_addr,
  input  logic                 imem_wen,
  input  logic [`MEM_STRB_R:0] imem_strb,
  input  logic [`MEM_DATA_R:0] imem_wdata,
  input  logic [`MEM_PRV_R:0]  imem_prv,
  output logic                 imem_gnt,
  output logic                 imem_err,
  output logic [`MEM_DATA_R:0] imem_rdata,

  input  logic                 dmem_req,
  input  logic [`MEM_ADDR_R:0] dmem_addr,
  input  logic                 dmem_wen,
  input  logic [`MEM_STRB_R:0] dmem_strb,
  input  logic [`MEM_DATA_R:0] dmem_wdata,
  input  logic [`MEM_PRV_R:0]  dmem_prv,
  output logic                 dmem_gnt,
  output logic                 dmem_err,
  output logic [`MEM_DATA_R:0] dmem_rdata,

  output logic                 mem_req,
  output logic                 mem_rtype,
  output logic                 mem_wen,
  output logic [`MEM_ADDR_R:0] mem_addr,
  output logic [`MEM_STRB_R:0] mem_strb,
  output logic [`MEM_DATA_R:0] mem_wdata,
  output logic [`MEM_PRV_R:0]  mem_prv,
  input  logic                 mem_gnt,
  input  logic                 mem_err,
  input  logic [`MEM_DATA_R:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state_q, state_d;
  logic   owner_valid;   // the current owner is actively requesting
  logic   owner_d;       // 1 = LSU owns the bus, 0 = fetch
  logic   tie_d;         // LSU wins when both request in IDLE
  logic   active;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_gnt_d;

  // Remember which port took the last grant so ties alternate.
  always_ff @(posedge g_clk) begin
    if (g_reset)      last_gnt_d <= 1'b1;
    else if (mem_gnt) last_gnt_d <= owner_d;
  end

  assign tie_d = ~last_gnt_d;
`else
  localparam int CNT_W = $clog2(FETCH_STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Count consecutive cycles fetch waits; at saturation fetch takes the next tie.
  always_ff @(posedge g_clk) begin
    if (g_reset || !imem_req || imem_gnt)
      starve_cnt <= '0;
    else if (starve_cnt != CNT_W'(FETCH_STARVE_MAX))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  assign tie_d = (starve_cnt != CNT_W'(FETCH_STARVE_MAX));
`endif

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge g_clk) begin
    if (g_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Owner selection and next state; a BUSY owner dropping req is a flush abort.
  always_comb begin
    owner_valid = 1'b0;
    owner_d     = 1'b0;
    state_d     = state_q;
    case (state_q)
      IDLE: begin
        owner_valid = imem_req | dmem_req;
        owner_d     = dmem_req & (~imem_req | tie_d);
        if (owner_valid && !mem_gnt) state_d = owner_d ? BUSY_D : BUSY_I;
      end
      BUSY_I: begin
        owner_valid = imem_req;
        if (!imem_req || mem_gnt) state_d = IDLE;
      end
      BUSY_D: begin
        owner_valid = dmem_req;
        owner_d     = 1'b1;
        if (!dmem_req || mem_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = owner_valid & ~g_reset;

  // Bus payload is steered straight from the owner with no registering.
  always_comb begin
    mem_req   = active;
    mem_rtype = active & owner_d;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_strb  = '0;
    mem_wdata = '0;
    mem_prv   = '0;
    if (active) begin
      mem_wen   = owner_d ? dmem_wen   : imem_wen;
      mem_addr  = owner_d ? dmem_addr  : imem_addr;
      mem_strb  = owner_d ? dmem_strb  : imem_strb;
      mem_wdata = owner_d ? dmem_wdata : imem_wdata;
      mem_prv   = owner_d ? dmem_prv   : imem_prv;
    end
  end

  assign imem_gnt   = mem_gnt & active & ~owner_d;
  assign dmem_gnt   = mem_gnt & active &  owner_d;
  assign imem_err   = mem_err & active & ~owner_d;
  assign dmem_err   = mem_err & active &  owner_d;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        imem_req, imem_wen, dmem_req, dmem_wen;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [3:0]  imem_strb, dmem_strb;
  logic [1:0]  imem_prv, dmem_prv;
  logic        imem_gnt, imem_err, dmem_gnt, dmem_err;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_req, mem_rtype, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strb;
  logic [1:0]  mem_prv;
  logic        mem_gnt, mem_err;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  core_mem_arbiter #(.FETCH_STARVE_MAX(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata), .imem_prv(imem_prv),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_prv(dmem_prv),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_rtype(mem_rtype), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_prv(mem_prv), .mem_gnt(mem_gnt), .mem_err(mem_err),
    .mem_rdata(mem_rdata)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset    = 1'b1;
    imem_req   = 1'b1; imem_addr = 32'h0000_1000; imem_wen = 1'b0;
    imem_strb  = 4'hf; imem_wdata = 32'h0;        imem_prv = 2'd3;
    dmem_req   = 1'b1; dmem_addr = 32'h0000_2000; dmem_wen = 1'b1;
    dmem_strb  = 4'h3; dmem_wdata = 32'hcafe_f00d; dmem_prv = 2'd1;
    mem_gnt    = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    #1;
    check("rst_mem_req",  mem_req,  1'b0);
    check("rst_imem_gnt", imem_gnt, 1'b0);
    check("rst_dmem_gnt", dmem_gnt, 1'b0);
    check("rst_imem_err", imem_err, 1'b0);
    check("rst_dmem_err", dmem_err, 1'b0);
    step();
    check("rst_state", dut.state_q, 2'd0);

    // Idle with no requests: bus quiet and payload zero.
    g_reset = 1'b0; imem_req = 1'b0; dmem_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
    #1;
    check("idle_mem_req",   mem_req,   1'b0);
    check("idle_mem_addr",  mem_addr,  32'h0);
    check("idle_mem_wdata", mem_wdata, 32'h0);

    // Fetch alone, granted the same cycle.
    step();
    imem_req = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hdead_beef;
    #1;
    check("f1_mem_req",    mem_req,    1'b1);
    check("f1_mem_addr",   mem_addr,   32'h0000_1000);
    check("f1_mem_rtype",  mem_rtype,  1'b0);
    check("f1_mem_prv",    mem_prv,    2'd3);
    check("f1_imem_gnt",   imem_gnt,   1'b1);
    check("f1_dmem_gnt",   dmem_gnt,   1'b0);
    check("f1_imem_rdata", imem_rdata, 32'hdead_beef);
    check("f1_dmem_rdata", dmem_rdata, 32'hdead_beef);

    // Still IDLE: a lone LSU request is taken immediately; no grant parks in BUSY_D.
    step();
    imem_req = 1'b0; dmem_req = 1'b1; mem_gnt = 1'b0;
    #1;
    check("d1_mem_rtype", mem_rtype, 1'b1);
    check("d1_mem_addr",  mem_addr,  32'h0000_2000);
    check("d1_mem_wdata", mem_wdata, 32'hcafe_f00d);
    check("d1_mem_strb",  mem_strb,  4'h3);
    check("d1_mem_wen",   mem_wen,   1'b1);

    // Flush abort in BUSY_D: bus drops, fetch is picked next cycle.
    step();
    dmem_req = 1'b0; imem_req = 1'b1;
    #1;
    check("abort_mem_req",  mem_req,  1'b0);
    check("abort_imem_gnt", imem_gnt, 1'b0);
    step();
    mem_gnt = 1'b1; mem_err = 1'b1;
    #1;
    check("abort_f_rtype", mem_rtype, 1'b0);
    check("abort_f_gnt",   imem_gnt,  1'b1);
    check("abort_f_ierr",  imem_err,  1'b1);
    check("abort_f_derr",  dmem_err,  1'b0);

    // Tie with delayed grant: LSU owns four cycles, fetch never granted.
    step();
    mem_err = 1'b0; dmem_req = 1'b1; imem_req = 1'b1; mem_gnt = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_gnt = 1'b1;
      #1;
      check("tie_rtype", mem_rtype, 1'b1);
      check("tie_addr",  mem_addr,  32'h0000_2000);
      check("tie_igrnt", imem_gnt,  1'b0);
      check("tie_dgrnt", dmem_gnt,  (c == 4));
      step();
    end
    dmem_req = 1'b0;
    #1;
    check("tie_next_igrnt", imem_gnt, 1'b1);
    check("tie_next_rtype", mem_rtype, 1'b0);

`ifndef CORE_MEM_ARB_RR_EN
    // Starvation: both held, granted every cycle; fetch wins on cycle 9.
    step();
    dmem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check("starve_igrnt", imem_gnt, (c == 9));
      check("starve_dgrnt", dmem_gnt, (c != 9));
      step();
    end
`else
    // Round-robin: last grant was fetch, so LSU first, then alternate.
    step();
    dmem_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("rr_dgrnt", dmem_gnt, (c % 2 == 1));
      check("rr_igrnt", imem_gnt, (c % 2 == 0));
      step();
    end
`endif

    // BUSY_I locks the owner, then reset abandons it.
    dmem_req = 1'b0; imem_req = 1'b1; mem_gnt = 1'b0;
    step();
    dmem_req = 1'b1;
    #1;
    check("lock_rtype", mem_rtype, 1'b0);
    check("lock_addr",  mem_addr,  32'h0000_1000);
    step();
    g_reset = 1'b1; mem_gnt = 1'b1;
    #1;
    check("rst2_mem_req",  mem_req,  1'b0);
    check("rst2_imem_gnt", imem_gnt, 1'b0);
    check("rst2_dmem_gnt", dmem_gnt, 1'b0);
    step();
    g_reset = 1'b0; imem_req = 1'b0; mem_gnt = 1'b0;
    #1;
    check("rst2_state",   dut.state_q, 2'd0);
    check("rst2_d_rtype", mem_rtype,   1'b1);
    check("rst2_d_req",   mem_req,     1'b1);
`ifndef CORE_MEM_ARB_RR_EN
    check("rst2_cnt", dut.starve_cnt, 4'd0);
`endif

`ifdef CORE_MEM_ARB_RR_EN
    // Round-robin after reset: fetch first, then alternate.
    imem_req = 1'b1; mem_gnt = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("rr0_igrnt", imem_gnt, (c % 2 == 1));
      check("rr0_dgrnt", dmem_gnt, (c % 2 == 0));
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter FETCH_STARVE_MAX, default 8, consecutive ungranted fetch-request cycles before fetch is promoted (fixed-priority mode only).
REQ-002 SHALL take address, data, strobe and privilege widths (MEM_ADDR_R, MEM_DATA_R, MEM_STRB_R, MEM_PRV_R) from core_common.svh.
REQ-003 g_clk  in  1  global clock; single clock domain.
REQ-004 g_reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  in  1  fetch-port request.
REQ-006 imem_addr/imem_wen/imem_strb/imem_wdata/imem_prv  in  MEM_ADDR_R+1/1/MEM_STRB_R+1/MEM_DATA_R+1/MEM_PRV_R+1  fetch payload.
REQ-007 imem_gnt, imem_err  out  1 each  fetch grant, fetch error.
REQ-008 imem_rdata  out  MEM_DATA_R+1  fetch read data.
REQ-009 dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata, dmem_prv  in  as REQ-005/006  LSU port.
REQ-010 dmem_gnt, dmem_err  out  1 each; dmem_rdata  out  MEM_DATA_R+1  LSU response.
REQ-011 mem_req, mem_rtype, mem_wen  out  1 each  shared-bus request, type (0=instr, 1=data), write enable.
REQ-012 mem_addr, mem_strb, mem_wdata, mem_prv  out  widths as REQ-006  shared-bus payload.
REQ-013 mem_gnt, mem_err  in  1 each; mem_rdata  in  MEM_DATA_R+1  shared-bus response, valid in the mem_gnt cycle.

Function
REQ-014 SHALL implement states IDLE, BUSY_I, BUSY_D; owner = selected requester in IDLE, else the BUSY owner.
REQ-015 SHALL drive mem_req and all mem_* payload combinationally from the owner, with zero cycles added latency.
REQ-016 SHALL drive mem_req = 0 and mem_* payload = 0 when neither port requests in IDLE.
REQ-017 IDLE, one requester: SHALL select it; mem_gnt in the same cycle keeps IDLE; no mem_gnt moves to BUSY_x.
REQ-018 IDLE, both requesting: SHALL select per REQ-026/REQ-027 policy.
REQ-019 BUSY_x: SHALL lock owner to x regardless of the other port; mem_gnt returns to IDLE next cycle.
REQ-020 BUSY_x with x_req deasserted (flush abort): SHALL drive mem_req = 0 that cycle and return to IDLE next cycle.
REQ-021 Requesters SHALL hold req and payload stable until grant; the arbiter SHALL not register payload.
REQ-022 imem_gnt = mem_gnt && owner==I; dmem_gnt = mem_gnt && owner==D; err gated identically.
REQ-023 SHALL broadcast mem_rdata to imem_rdata and dmem_rdata unmodified.
REQ-024 SHALL set mem_rtype = 1 when owner is D, 0 otherwise.
REQ-025 Back-to-back: SHALL permit a new grant in the cycle immediately following IDLE return; no dead cycle.

Configuration
REQ-026 Without CORE_MEM_ARB_RR_EN: data wins ties; a counter SHALL increment each cycle imem_req=1 && !imem_gnt, saturating at FETCH_STARVE_MAX, and clearing on imem_gnt or imem_req=0; at saturation fetch SHALL win the next IDLE tie.
REQ-027 With CORE_MEM_ARB_RR_EN: SHALL keep a last-granted flop updated on each mem_gnt; ties SHALL go to the port not last granted; starvation counter SHALL not be built.

Reset
REQ-028 While g_reset=1: state IDLE, starvation counter 0, last-granted = D (fetch wins first tie).
REQ-029 While g_reset=1: mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err SHALL be 0.
REQ-030 Reset asserted in BUSY_x SHALL abandon the transaction; IDLE on the first post-reset cycle.

Verification
REQ-031 imem_req only, mem_gnt same cycle, addr 0x1000 -> mem_addr=0x1000, mem_rtype=0, imem_gnt=1, state stays IDLE.
REQ-032 Both request, mem_gnt delayed 3 cycles, non-RR -> D owns for 4 cycles, mem_rtype=1, imem_gnt=0 throughout, then fetch granted next cycle.
REQ-033 Non-RR, dmem_req held with gnt each cycle, imem_req held -> fetch granted on or before cycle FETCH_STARVE_MAX+1 (9).
REQ-034 RR build, both held, mem_gnt every cycle -> grants alternate I,D,I,D starting with I after reset.
REQ-035 BUSY_D, dmem_req dropped -> mem_req=0 that cycle, IDLE next; pending imem_req granted then.
REQ-036 g_reset pulsed in BUSY_I -> mem_req=0, no gnt during reset, IDLE after, counter 0.
